apb_csr_timer_bank: RTL and testbench

//  Parametrised APB CSR slave: global ID/IRQ registers plus NUM_CH down-counter channels.

---
 rtl/apb_csr_timer_bank.sv | 181 ++++++++++++++++++
 tb/tb_apb_csr_timer_bank.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_csr_timer_bank.sv
// APB CSR slave: global ID/IRQ registers plus NUM_CH programmable down-counter channels,
// with inserted wait states, PSLVERR decode, PSTRB byte masking and a W1C interrupt status.
module apb_csr_timer_bank #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [3:0]            PSTRB,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  irq
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state, state_next;
    logic [2:0]           wait_cnt, wait_next;

    logic [7:0]           off;
    logic [3:0]           slot;
    logic [1:0]           word;
    logic                 in_ch;
    logic                 err;
    logic                 wr_en;
    logic [31:0]          strb_mask;
    logic [31:0]          rd;

    logic [NUM_CH-1:0]    irq_status, irq_en, irq_clr;
    logic [NUM_CH-1:0]    en_r, ar_r, expire;
    logic [NUM_CH-1:0]    wr_ctrl, wr_load;
    logic [CNT_WIDTH-1:0] load_r  [NUM_CH];
    logic [CNT_WIDTH-1:0] count_r [NUM_CH];

    logic                 unused_bits;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    state_next = SETUP;
                    wait_next  = '0;
                end
            end
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                if (PREADY || !PSELx) state_next = IDLE;
                else if (wait_cnt < 3'(WAIT_STATES)) wait_next = wait_cnt + 3'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign PREADY = PSELx && PENABLE && (state == ACCESS) && (wait_cnt == 3'(WAIT_STATES));

    // Only the low address byte is decoded; slot 0 is the global block, slots 1.. are channels.
    assign off   = PADDR[7:0];
    assign slot  = off[7:4];
    assign word  = off[3:2];
    assign in_ch = (slot != 4'd0) && (off < 8'h90);

    always_comb begin
        err = 1'b0;
        if (off[1:0] != 2'b00 || off == 8'h0C || off >= 8'h90) err = 1'b1;
        if (in_ch && (word == 2'd3 || int'(slot) > NUM_CH))  err = 1'b1;
        if (PWRITE && (off == 8'h00 || (in_ch && word == 2'd2))) err = 1'b1;
    end

    assign PSLVERR   = PREADY && err;
    assign wr_en     = PREADY && PWRITE && !err;
    assign strb_mask = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
    assign irq_clr   = (wr_en && slot == 4'd0 && word == 2'd1) ?
                       (PWDATA[NUM_CH-1:0] & strb_mask[NUM_CH-1:0]) : '0;

    always_comb begin
        wr_ctrl = '0;
        wr_load = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            wr_ctrl[n] = wr_en && (slot == 4'(n + 1)) && (word == 2'd0);
            wr_load[n] = wr_en && (slot == 4'(n + 1)) && (word == 2'd1);
            expire[n]  = en_r[n] && (count_r[n] == '0);
        end
    end

    // Hardware set is OR-ed in after the clear, so an expiry beats a same-cycle W1C.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_status <= '0;
            irq_en     <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | expire;
            if (wr_en && slot == 4'd0 && word == 2'd2)
                irq_en <= (irq_en & ~strb_mask[NUM_CH-1:0]) | (PWDATA[NUM_CH-1:0] & strb_mask[NUM_CH-1:0]);
        end
    end

    // NOTE: the per-channel arrays are architecturally visible, so they are reset like any register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en_r <= '0;
            ar_r <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                load_r[n]  <= '0;
                count_r[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                // A masked CTRL lane keeps the old bits, which also overrides the HW en-clear.
                if (wr_ctrl[n]) begin
                    en_r[n] <= PSTRB[0] ? PWDATA[0] : en_r[n];
                    ar_r[n] <= PSTRB[0] ? PWDATA[1] : ar_r[n];
                end else if (expire[n] && !ar_r[n]) begin
                    en_r[n] <= 1'b0;
                end

                if (wr_ctrl[n] && PSTRB[0] && PWDATA[0] && !en_r[n]) begin
                    count_r[n] <= load_r[n];
                end else if (en_r[n]) begin
                    if (count_r[n] != '0) count_r[n] <= count_r[n] - CNT_WIDTH'(1);
                    else if (ar_r[n])     count_r[n] <= load_r[n];
                end

                if (wr_load[n])
                    load_r[n] <= (load_r[n] & ~strb_mask[CNT_WIDTH-1:0]) |
                                 (PWDATA[CNT_WIDTH-1:0] & strb_mask[CNT_WIDTH-1:0]);
            end
        end
    end

    always_comb begin
        rd = '0;
        if (slot == 4'd0) begin
            case (word)
                2'd0:    rd = {16'h5A02, 8'(NUM_CH), 8'(CNT_WIDTH)};
                2'd1:    rd = 32'(irq_status);
                2'd2:    rd = 32'(irq_en);
                default: rd = '0;
            endcase
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (slot == 4'(n + 1)) begin
                    case (word)
                        2'd0:    rd = {30'b0, ar_r[n], en_r[n]};
                        2'd1:    rd = 32'(load_r[n]);
                        2'd2:    rd = 32'(count_r[n]);
                        default: rd = '0;
                    endcase
                end
            end
        end
    end

    assign PRDATA = (state == ACCESS && !err) ? rd : '0;
    assign irq    = |(irq_status & irq_en);

    assign unused_bits = ^{PADDR, PWDATA, strb_mask};

endmodule

// File: tb/tb_apb_csr_timer_bank.sv
// Self-checking bench for apb_csr_timer_bank: directed scenarios then randomized APB traffic,
// compared every cycle against a register-level reference model of the timer bank.
module tb_apb_csr_timer_bank;

    localparam int          NCH   = 4;
    localparam int          CW    = 16;
    localparam int          WS    = 3;
    localparam logic [31:0] CMASK = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PADDR = '0;
    logic        PSELx = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_en   [NCH];
    bit          m_ar   [NCH];
    int unsigned m_load [NCH];
    int unsigned m_cnt  [NCH];
    bit [NCH-1:0] m_st;
    bit [NCH-1:0] m_ie;

    apb_csr_timer_bank #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_CH     (NCH),
        .CNT_WIDTH  (CW),
        .WAIT_STATES(WS)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .PADDR  (PADDR),
        .PSELx  (PSELx),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PWDATA (PWDATA),
        .PSTRB  (PSTRB),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] lane_mask(input bit [3:0] s);
        bit [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic bit exp_err(input bit [7:0] off, input bit wr);
        int o = int'(off);
        if (o % 4 != 0) return 1'b1;
        if (o < 16)     return (o == 12) || (wr && o == 0);
        if (o >= 144)   return 1'b1;
        return ((o - 16) / 16 >= NCH) || ((o % 16) / 4 == 3) || (wr && (o % 16) / 4 == 2);
    endfunction

    function automatic logic [31:0] model_read(input bit [7:0] off);
        int ch, r;
        if (off == 8'h00) return 32'h5A02_0410;
        if (off == 8'h04) return 32'(m_st);
        if (off == 8'h08) return 32'(m_ie);
        ch = (int'(off) - 16) / 16;
        r  = (int'(off) % 16) / 4;
        if (r == 0) return {30'b0, m_ar[ch], m_en[ch]};
        if (r == 1) return m_load[ch];
        return m_cnt[ch];
    endfunction

    function automatic bit model_irq();
        return |(m_st & m_ie);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_en[n] = 1'b0; m_ar[n] = 1'b0; m_load[n] = 0; m_cnt[n] = 0;
        end
        m_st = '0;
        m_ie = '0;
    endtask

    // One clock of the timer bank: counters advance from the old state, then a committed write lands.
    task automatic model_step(input bit wr, input bit [7:0] off, input bit [31:0] d, input bit [3:0] s);
        bit [31:0]    mask;
        bit [NCH-1:0] fired;
        int unsigned  nxt_cnt [NCH];
        bit           nxt_en  [NCH];
        int           ch, r;
        bit           e, a;
        mask  = lane_mask(s);
        fired = '0;
        for (int n = 0; n < NCH; n++) begin
            nxt_cnt[n] = m_cnt[n];
            nxt_en[n]  = m_en[n];
            if (m_en[n] && m_cnt[n] > 0) nxt_cnt[n] = m_cnt[n] - 1;
            else if (m_en[n]) begin
                fired[n] = 1'b1;
                if (m_ar[n]) nxt_cnt[n] = m_load[n];
                else         nxt_en[n]  = 1'b0;
            end
        end
        if (wr) begin
            if (off == 8'h04) m_st = m_st & ~(d[NCH-1:0] & mask[NCH-1:0]);
            else if (off == 8'h08) m_ie = (m_ie & ~mask[NCH-1:0]) | (d[NCH-1:0] & mask[NCH-1:0]);
            else if (off >= 8'h10) begin
                ch = (int'(off) - 16) / 16;
                r  = (int'(off) % 16) / 4;
                if (r == 0) begin
                    e = s[0] ? d[0] : m_en[ch];
                    a = s[0] ? d[1] : m_ar[ch];
                    if (e && !m_en[ch]) nxt_cnt[ch] = m_load[ch];
                    nxt_en[ch] = e;
                    m_ar[ch]   = a;
                end else if (r == 1) begin
                    m_load[ch] = ((m_load[ch] & ~mask) | (d & mask)) & CMASK;
                end
            end
        end
        m_st = m_st | fired;
        for (int n = 0; n < NCH; n++) begin
            m_cnt[n] = nxt_cnt[n];
            m_en[n]  = nxt_en[n];
        end
    endtask

    task automatic step(input bit wr = 1'b0, input bit [7:0] off = 8'h0,
                        input bit [31:0] d = 32'h0, input bit [3:0] s = 4'h0);
        @(posedge clk);
        model_step(wr, off, d, s);
        @(negedge clk);
        check("irq", {31'b0, irq}, {31'b0, model_irq()});
    endtask

    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rdata, output logic slverr);
        bit [7:0] off;
        bit       e;
        int       waits;
        off = addr[7:0];
        e   = exp_err(off, wr);
        PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = d; PSTRB = s;
        step();
        PENABLE = 1'b1;
        #1;
        waits = 0;
        while (PREADY !== 1'b1 && waits < 20) begin
            step();
            waits++;
        end
        check("wait_cycles", waits, WS + 1);
        check("pslverr", {31'b0, PSLVERR}, {31'b0, e});
        if (!wr) check("prdata", PRDATA, e ? 32'h0 : model_read(off));
        rdata  = PRDATA;
        slverr = PSLVERR;
        step(wr && !e, off, d, s);
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        se;
        int          k;
        bit [7:0]    offs [16] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24,
                                   8'h34, 8'h40, 8'h44, 8'h0C, 8'h02, 8'h1C, 8'h50, 8'h90};
        model_reset();

        // Reset state
        step();
        step();
        check("rst_pready",  {31'b0, PREADY},  32'h0);
        check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
        check("rst_prdata",  PRDATA,           32'h0);
        rst_n = 1'b1;
        step();

        // ID read with wait states
        apb(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, se);
        check("id_value", rd, 32'h5A02_0410);

        // Byte-lane masked LOAD write
        apb(1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'b0010, rd, se);
        apb(1'b0, 32'h0000_0014, 32'h0, 4'h0, rd, se);
        check("load_pstrb", rd, 32'h0000_CC00);

        // One-shot countdown on channel 0: irq exactly LOAD+1 cycles after enable
        apb(1'b1, 32'h0000_0014, 32'd5, 4'hF, rd, se);
        apb(1'b1, 32'h0000_0008, 32'd1, 4'hF, rd, se);
        apb(1'b1, 32'h0000_0010, 32'd1, 4'hF, rd, se);
        k = 0;
        while (irq !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check("ch0_period", k, 6);
        apb(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, se);
        check("ch0_en_cleared", rd, 32'h0);
        apb(1'b0, 32'h0000_0018, 32'h0, 4'h0, rd, se);
        check("ch0_count_zero", rd, 32'h0);
        apb(1'b0, 32'h0000_0004, 32'h0, 4'h0, rd, se);
        check("ch0_status", rd, 32'h1);

        // Channel 1 auto-reload, W1C racing a hardware set
        apb(1'b1, 32'h0000_0024, 32'd2, 4'hF, rd, se);
        apb(1'b1, 32'h0000_0008, 32'd3, 4'hF, rd, se);
        apb(1'b1, 32'h0000_0020, 32'd3, 4'hF, rd, se);
        apb(1'b1, 32'h0000_0004, 32'd1, 4'hF, rd, se);
        k = 0;
        while (!(m_en[1] && m_cnt[1] == 2) && k < 10) begin step(); k++; end
        apb(1'b1, 32'h0000_0004, 32'd2, 4'hF, rd, se);
        check("w1c_hw_wins", {31'b0, irq}, 32'h1);
        k = 0;
        while (!(m_en[1] && m_cnt[1] == 0) && k < 10) begin step(); k++; end
        apb(1'b1, 32'h0000_0004, 32'd2, 4'hF, rd, se);
        check("w1c_clear", {31'b0, irq}, 32'h0);
        apb(1'b1, 32'h0000_0020, 32'd0, 4'hF, rd, se);
        apb(1'b1, 32'h0000_0004, 32'hF, 4'hF, rd, se);

        // Error decode: no side effects, zero read data
        apb(1'b1, 32'h0000_0018, 32'h0000_1234, 4'hF, rd, se);
        check("err_wr_count", {31'b0, se}, 32'h1);
        apb(1'b0, 32'h0000_000C, 32'h0, 4'h0, rd, se);
        check("err_rd_0c", rd, 32'h0);
        apb(1'b0, 32'h0000_0002, 32'h0, 4'h0, rd, se);
        check("err_rd_02", {31'b0, se}, 32'h1);
        apb(1'b0, 32'h0000_0050, 32'h0, 4'h0, rd, se);
        check("err_rd_50", {31'b0, se}, 32'h1);
        apb(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, rd, se);
        apb(1'b0, 32'hFFFF_FF90, 32'h0, 4'h0, rd, se);
        apb(1'b0, 32'h0000_0018, 32'h0, 4'h0, rd, se);
        apb(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, se);

        // Aborted transfer leaves IRQ_EN untouched
        PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_0008; PWRITE = 1'b1; PWDATA = 32'h0; PSTRB = 4'hF;
        step();
        PENABLE = 1'b1;
        step();
        step();
        PSELx = 1'b0; PENABLE = 1'b0;
        step();
        apb(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, se);
        check("abort_no_write", rd, 32'h3);

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            bit [7:0]  o;
            bit [31:0] d;
            bit        w;
            o = offs[$urandom_range(0, 15)];
            w = $urandom_range(0, 1) == 1;
            d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 10)) : $urandom;
            apb(w, ($urandom & 32'hFFFF_FF00) | 32'(o), d, 4'($urandom_range(0, 15)), rd, se);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        // Reset during a countdown and mid-ACCESS
        apb(1'b1, 32'h0000_0014, 32'd20, 4'hF, rd, se);
        apb(1'b1, 32'h0000_0008, 32'd1, 4'hF, rd, se);
        apb(1'b1, 32'h0000_0010, 32'd3, 4'hF, rd, se);
        step();
        PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_0018; PWRITE = 1'b0; PSTRB = 4'h0;
        step();
        PENABLE = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_pready", {31'b0, PREADY}, 32'h0);
        check("midrst_irq",    {31'b0, irq},    32'h0);
        check("midrst_prdata", PRDATA,          32'h0);
        PSELx = 1'b0; PENABLE = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();
        apb(1'b0, 32'h0000_0018, 32'h0, 4'h0, rd, se);
        check("post_rst_count", rd, 32'h0);
        apb(1'b0, 32'h0000_0014, 32'h0, 4'h0, rd, se);
        check("post_rst_load", rd, 32'h0);
        apb(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, se);
        apb(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, se);
        apb(1'b0, 32'h0000_0004, 32'h0, 4'h0, rd, se);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
